// File: rtl/pc_ir_unit_if.sv
// Instruction-memory fetch port of the PC/IR stage.
// The unit is the master: it presents the address and request, memory answers.
interface pc_ir_unit_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] imem_addr;
    logic              imem_req;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_ready;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/pc_ir_unit.sv
// Program counter and instruction register stage of the 16-bit multicycle core.
// Owns the fetch handshake and stalls the controller while memory is slow.
module pc_ir_unit #(
    parameter int               DATA_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        PCSrc,
    input  logic              PCWrite,
    input  logic              PCBEqCond,
    input  logic              PCBNqCond,
    input  logic              IRWrite,
    input  logic              zero,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_out,
    pc_ir_unit_if.master      imem,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        opcode,
    output logic [3:0]        func_field,
    output logic              ir_valid,
    output logic              fetch_busy
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] ir_d;
    logic              ir_valid_q;
    logic              ir_valid_d;
    logic [DATA_W-1:0] pc_pend_q;
    logic [DATA_W-1:0] pc_pend_d;
    logic              pend_en_q;
    logic              pend_en_d;
    logic [DATA_W-1:0] next_pc;
    logic              pc_en;
    logic              req;
    logic              busy;

    assign pc_en = PCWrite
                 | (PCBEqCond & zero)
                 | (PCBNqCond & ~zero);

    always_comb begin
        next_pc = pc_q;
        case (PCSrc)
            2'b00: next_pc = alu_result;
            2'b01: next_pc = {pc_q[DATA_W-1 -: 4],
                              ir_q[DATA_W-5:0]};
            2'b10: next_pc = alu_out;
            2'b11: next_pc = pc_q;
            default: next_pc = pc_q;
        endcase
    end

    // Controller inputs are don't-care in WAIT: the core has frozen it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        pc_pend_d  = pc_pend_q;
        pend_en_d  = pend_en_q;
        req        = 1'b0;
        busy       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (IRWrite) begin
                    req = 1'b1;
                    if (imem.imem_ready) begin
                        ir_d       = imem.imem_rdata;
                        ir_valid_d = 1'b1;
                        if (pc_en) pc_d = next_pc;
                    end else begin
                        busy      = 1'b1;
                        pc_pend_d = next_pc;
                        pend_en_d = pc_en;
                        state_d   = S_WAIT;
                    end
                end else if (pc_en) begin
                    pc_d = next_pc;
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (imem.imem_ready) begin
                    ir_d       = imem.imem_rdata;
                    ir_valid_d = 1'b1;
                    if (pend_en_q) pc_d = pc_pend_q;
                    state_d    = S_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            pc_pend_q  <= '0;
            pend_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            pc_pend_q  <= pc_pend_d;
            pend_en_q  <= pend_en_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = req;
    assign fetch_busy     = busy;
    assign pc             = pc_q;
    assign ir             = ir_q;
    assign ir_valid       = ir_valid_q;
    assign opcode         = ir_q[DATA_W-1 -: 4];
    assign func_field     = ir_q[3:0];

endmodule

// File: tb/tb_pc_ir_unit.sv
// Bench for pc_ir_unit: directed vector table, hand sequences for wait
// states and reset-in-wait, then random traffic against a reference model.
module tb_pc_ir_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PCSrc;
    logic        PCWrite;
    logic        PCBEqCond;
    logic        PCBNqCond;
    logic        IRWrite;
    logic        zero;
    logic [15:0] alu_result;
    logic [15:0] alu_out;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  func_field;
    logic        ir_valid;
    logic        fetch_busy;

    int n_chk  = 0;
    int n_pass = 0;

    pc_ir_unit_if #(.DATA_W(16)) bus ();

    pc_ir_unit #(
        .DATA_W  (16),
        .RESET_PC(16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PCSrc     (PCSrc),
        .PCWrite   (PCWrite),
        .PCBEqCond (PCBEqCond),
        .PCBNqCond (PCBNqCond),
        .IRWrite   (IRWrite),
        .zero      (zero),
        .alu_result(alu_result),
        .alu_out   (alu_out),
        .imem      (bus),
        .pc        (pc),
        .ir        (ir),
        .opcode    (opcode),
        .func_field(func_field),
        .ir_valid  (ir_valid),
        .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  src;
        logic        pcw;
        logic        beq;
        logic        bnq;
        logic        irw;
        logic        zero;
        logic [15:0] ares;
        logic [15:0] aout;
        logic [15:0] rdata;
        logic        ready;
        logic [15:0] e_pc;
        logic [15:0] e_ir;
        logic        e_valid;
        logic        e_busy;
    } vec_t;

    vec_t tbl[11];

    // Reference model state, written in terms of the fetch rules only.
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic        m_valid;
    logic        m_waiting;
    logic [15:0] m_pend_pc;
    logic        m_pend_do;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    task automatic quiet();
        rst             = 1'b1;
        PCSrc           = 2'b00;
        PCWrite         = 1'b0;
        PCBEqCond       = 1'b0;
        PCBNqCond       = 1'b0;
        IRWrite         = 1'b0;
        zero            = 1'b0;
        alu_result      = 16'h0;
        alu_out         = 16'h0;
        bus.imem_rdata  = 16'h0;
        bus.imem_ready  = 1'b0;
    endtask

    // Settle inputs, cross the rising edge, land 1 time unit past it.
    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic [15:0] e_pc,
                            input logic [15:0] e_ir, input logic e_v);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".ir"}, ir, e_ir);
        chk({tag, ".ir_valid"}, {15'h0, ir_valid}, {15'h0, e_v});
        chk({tag, ".opcode"}, {12'h0, opcode}, {12'h0, e_ir[15:12]});
        chk({tag, ".func"}, {12'h0, func_field}, {12'h0, e_ir[3:0]});
    endtask

    function automatic logic [15:0] model_next(input logic [1:0] s);
        logic [15:0] n;
        if (s == 2'd0)      n = alu_result;
        else if (s == 2'd1) n = {m_pc[15:12], m_ir[11:0]};
        else if (s == 2'd2) n = alu_out;
        else                n = m_pc;
        return n;
    endfunction

    task automatic model_step();
        logic [15:0] n;
        logic        w;
        n = model_next(PCSrc);
        w = PCWrite || (PCBEqCond && zero) || (PCBNqCond && !zero);
        if (!rst) begin
            m_pc = 16'h0; m_ir = 16'h0; m_valid = 1'b0;
            m_waiting = 1'b0; m_pend_pc = 16'h0; m_pend_do = 1'b0;
        end else if (m_waiting) begin
            if (bus.imem_ready) begin
                m_ir = bus.imem_rdata; m_valid = 1'b1;
                if (m_pend_do) m_pc = m_pend_pc;
                m_waiting = 1'b0;
            end
        end else if (IRWrite) begin
            if (bus.imem_ready) begin
                m_ir = bus.imem_rdata; m_valid = 1'b1;
                if (w) m_pc = n;
            end else begin
                m_waiting = 1'b1; m_pend_pc = n; m_pend_do = w;
            end
        end else if (w) begin
            m_pc = n;
        end
    endtask

    initial begin
        quiet();
        //          rst src pcw beq bnq irw z  ares      aout      rdata     rdy  pc        ir        v  busy
        tbl[0]  = '{0, 2'd0, 0, 0, 0, 1, 0, 16'h1111, 16'h0000, 16'h1234, 1, 16'h0000, 16'h0000, 0, 0};
        tbl[1]  = '{0, 2'd0, 0, 0, 0, 1, 0, 16'h1111, 16'h0000, 16'h1234, 1, 16'h0000, 16'h0000, 0, 0};
        tbl[2]  = '{1, 2'd0, 1, 0, 0, 1, 0, 16'h0002, 16'h0000, 16'h8123, 1, 16'h0002, 16'h8123, 1, 0};
        tbl[3]  = '{1, 2'd2, 0, 1, 0, 0, 1, 16'h0000, 16'h0040, 16'h0000, 0, 16'h0040, 16'h8123, 1, 0};
        tbl[4]  = '{1, 2'd2, 0, 1, 0, 0, 0, 16'h0000, 16'h0080, 16'h0000, 0, 16'h0040, 16'h8123, 1, 0};
        tbl[5]  = '{1, 2'd2, 0, 0, 1, 0, 0, 16'h0000, 16'h0060, 16'h0000, 0, 16'h0060, 16'h8123, 1, 0};
        tbl[6]  = '{1, 2'd0, 1, 1, 1, 0, 1, 16'h0100, 16'h0000, 16'h0000, 0, 16'h0100, 16'h8123, 1, 0};
        tbl[7]  = '{1, 2'd0, 1, 0, 0, 1, 0, 16'h5006, 16'h0000, 16'h3ABC, 1, 16'h5006, 16'h3ABC, 1, 0};
        tbl[8]  = '{1, 2'd1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h5ABC, 16'h3ABC, 1, 0};
        tbl[9]  = '{1, 2'd0, 1, 0, 0, 0, 0, 16'h5006, 16'h0000, 16'h0000, 0, 16'h5006, 16'h3ABC, 1, 0};
        tbl[10] = '{1, 2'd3, 1, 0, 0, 0, 0, 16'hDEAD, 16'hBEEF, 16'h0000, 0, 16'h5006, 16'h3ABC, 1, 0};

        @(negedge clk);
        foreach (tbl[i]) begin
            rst = tbl[i].rst; PCSrc = tbl[i].src; PCWrite = tbl[i].pcw;
            PCBEqCond = tbl[i].beq; PCBNqCond = tbl[i].bnq;
            IRWrite = tbl[i].irw; zero = tbl[i].zero;
            alu_result = tbl[i].ares; alu_out = tbl[i].aout;
            bus.imem_rdata = tbl[i].rdata; bus.imem_ready = tbl[i].ready;
            #1;
            chk($sformatf("vec%0d.busy", i), {15'h0, fetch_busy},
                {15'h0, tbl[i].e_busy});
            edge_();
            chk_regs($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_ir,
                     tbl[i].e_valid);
            @(negedge clk);
        end

        // Wrap: FFFE + 2 arrives as 0000 through alu_result.
        quiet(); PCWrite = 1'b1; alu_result = 16'hFFFE;
        edge_(); @(negedge clk);
        alu_result = 16'h0000;
        edge_();
        chk("wrap.pc", pc, 16'h0000);
        @(negedge clk);

        // Three wait states; pending target must survive input changes.
        quiet(); rst = 1'b0;
        edge_(); @(negedge clk);
        quiet(); IRWrite = 1'b1; PCWrite = 1'b1;
        alu_result = 16'h0002; bus.imem_rdata = 16'h8123;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("ws%0d.busy", k), {15'h0, fetch_busy}, 16'h1);
            chk($sformatf("ws%0d.req", k), {15'h0, bus.imem_req}, 16'h1);
            chk($sformatf("ws%0d.addr", k), bus.imem_addr, 16'h0000);
            edge_();
            chk($sformatf("ws%0d.pc", k), pc, 16'h0000);
            chk($sformatf("ws%0d.valid", k), {15'h0, ir_valid}, 16'h0);
            @(negedge clk);
            IRWrite = 1'b0; PCWrite = 1'b0; alu_result = 16'h7777;
        end
        bus.imem_ready = 1'b1;
        #1;
        chk("ws.rdy.busy", {15'h0, fetch_busy}, 16'h0);
        chk("ws.rdy.req", {15'h0, bus.imem_req}, 16'h1);
        edge_();
        chk_regs("ws.done", 16'h0002, 16'h8123, 1'b1);
        @(negedge clk);

        // Reset while waiting abandons the fetch.
        quiet(); PCWrite = 1'b1; alu_result = 16'h0010;
        edge_(); @(negedge clk);
        quiet(); IRWrite = 1'b1; PCWrite = 1'b1; alu_result = 16'h0012;
        edge_();
        chk("rw.enter.pc", pc, 16'h0010);
        @(negedge clk);
        quiet(); rst = 1'b0;
        edge_();
        chk_regs("rw.rst", 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        quiet(); bus.imem_ready = 1'b1; bus.imem_rdata = 16'hF00D;
        #1;
        chk("rw.idle.req", {15'h0, bus.imem_req}, 16'h0);
        chk("rw.idle.busy", {15'h0, fetch_busy}, 16'h0);
        edge_();
        chk_regs("rw.after", 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);

        // Random traffic against the model, starting from a known reset.
        quiet(); rst = 1'b0;
        model_step();
        edge_(); @(negedge clk);
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 24) != 0);
            PCSrc      = 2'($urandom_range(0, 3));
            PCWrite    = ($urandom_range(0, 3) == 0);
            PCBEqCond  = ($urandom_range(0, 3) == 0);
            PCBNqCond  = ($urandom_range(0, 3) == 0);
            IRWrite    = ($urandom_range(0, 2) == 0);
            zero       = 1'($urandom_range(0, 1));
            alu_result = 16'($urandom);
            alu_out    = 16'($urandom);
            bus.imem_rdata = 16'($urandom);
            bus.imem_ready = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("rnd%0d.req", c), {15'h0, bus.imem_req},
                {15'h0, m_waiting | IRWrite});
            chk($sformatf("rnd%0d.busy", c), {15'h0, fetch_busy},
                {15'h0, (m_waiting | IRWrite) & ~bus.imem_ready});
            chk($sformatf("rnd%0d.addr", c), bus.imem_addr, m_pc);
            model_step();
            edge_();
            chk($sformatf("rnd%0d.pc", c), pc, m_pc);
            chk($sformatf("rnd%0d.ir", c), ir, m_ir);
            chk($sformatf("rnd%0d.valid", c), {15'h0, ir_valid},
                {15'h0, m_valid});
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
